// File: rtl/coin_entry_debounce_if.sv
// Coin entry bus: raw button/switch inputs toward the debouncer, and the
// clean coin strobe, code, status and press count back toward the consumer.
interface coin_entry_debounce_if;
  logic       BTNC;
  logic       SW0;
  logic       SW1;
  logic       COIN_VALID;
  logic [1:0] COIN_CODE;
  logic       BUSY;
  logic [7:0] PRESS_CNT;

  // Side that owns the button and switches and consumes the coin strobe.
  modport master (
    output BTNC, SW0, SW1,
    input  COIN_VALID, COIN_CODE, BUSY, PRESS_CNT
  );

  // Debouncer side.
  modport slave (
    input  BTNC, SW0, SW1,
    output COIN_VALID, COIN_CODE, BUSY, PRESS_CNT
  );
endinterface

// File: rtl/coin_entry_debounce.sv
// Coin entry front end: synchronizes the raw push-button and coin-select
// switches, debounces the button on both press and release, and turns each
// clean press into a single-cycle COIN_VALID strobe carrying the coin code
// sampled at that instant. DEBOUNCE_CYCLES and SYNC_STAGES must both be >= 2.
module coin_entry_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input logic                  CLK,
  input logic                  RST,
  coin_entry_debounce_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] btn_sync;
  logic [SYNC_STAGES-1:0] sw0_sync;
  logic [SYNC_STAGES-1:0] sw1_sync;
  logic                   btn_s;
  logic [1:0]             sw_s;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;

  logic                   coin_valid;
  logic                   coin_valid_nxt;
  logic [1:0]             coin_code;
  logic [1:0]             coin_code_nxt;
  logic                   busy;
  logic                   busy_nxt;
  logic [7:0]             press_cnt;
  logic [7:0]             press_cnt_nxt;
  logic                   accept;

  // Synchronizer chains: raw inputs enter only here, oldest sample at the MSB.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      btn_sync <= '0;
      sw0_sync <= '0;
      sw1_sync <= '0;
    end else begin
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], bus.BTNC};
      sw0_sync <= {sw0_sync[SYNC_STAGES-2:0], bus.SW0};
      sw1_sync <= {sw1_sync[SYNC_STAGES-2:0], bus.SW1};
    end
  end

  assign btn_s = btn_sync[SYNC_STAGES-1];
  assign sw_s  = {sw1_sync[SYNC_STAGES-1], sw0_sync[SYNC_STAGES-1]};

  // State, stability counter and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      coin_valid <= 1'b0;
      coin_code  <= 2'b00;
      busy       <= 1'b0;
      press_cnt  <= 8'd0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      coin_valid <= coin_valid_nxt;
      coin_code  <= coin_code_nxt;
      busy       <= busy_nxt;
      press_cnt  <= press_cnt_nxt;
    end
  end

  // Next state and counter: cnt tracks how long btn_s has held its new level.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (btn_s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HELD: begin
        cnt_nxt = '0;
        if (!btn_s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          // Release bounce: fall back to HELD without a new strobe.
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output values: strobe, code capture and count advance only on acceptance.
  always_comb begin
    accept         = (state == PRESS_WAIT) && btn_s && (cnt == CNT_LAST);
    coin_valid_nxt = accept;
    coin_code_nxt  = accept ? sw_s : coin_code;
    press_cnt_nxt  = accept ? press_cnt + 8'd1 : press_cnt;
    busy_nxt       = (state_nxt != IDLE);
  end

  assign bus.COIN_VALID = coin_valid;
  assign bus.COIN_CODE  = coin_code;
  assign bus.BUSY       = busy;
  assign bus.PRESS_CNT  = press_cnt;

endmodule

// File: tb/tb_coin_entry_debounce.sv
// Bench for coin_entry_debounce with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Each press pushes its expected code, count and strobe cycle to a queue;
// a negedge monitor pops and compares whenever COIN_VALID is seen.
module tb_coin_entry_debounce;

  localparam int DEB     = 4;
  localparam int SYNC    = 2;
  localparam int LATENCY = DEB + SYNC;

  typedef struct {
    logic [1:0] code;
    logic [7:0] cnt;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] exp_cnt = 8'd0;
  exp_t q[$];

  coin_entry_debounce_if bus();

  coin_entry_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES(SYNC)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_strobe(input logic [1:0] code);
    exp_t e;
    exp_cnt = exp_cnt + 8'd1;
    e.code = code;
    e.cnt  = exp_cnt;
    e.due  = cyc + LATENCY;
    q.push_back(e);
  endtask

  // Clean press: drive switches, hold the button, release and let it settle.
  task automatic press(input logic [1:0] code, input int hold);
    {bus.SW1, bus.SW0} = code;
    tick(1);
    bus.BTNC = 1'b1;
    expect_strobe(code);
    tick(hold);
    bus.BTNC = 1'b0;
    tick(10);
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected press.
  always @(negedge clk) begin
    if (!rst && bus.COIN_VALID === 1'b1) begin
      chk("sb_nonempty", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("strobe_code", 32'(bus.COIN_CODE), 32'(e.code));
        chk("strobe_cnt", 32'(bus.PRESS_CNT), 32'(e.cnt));
        chk("strobe_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.BTNC = 1'b0;
    bus.SW0  = 1'b0;
    bus.SW1  = 1'b0;
    #1 rst = 1'b1;
    tick(3);
    chk("rst_valid", 32'(bus.COIN_VALID), 32'd0);
    chk("rst_code", 32'(bus.COIN_CODE), 32'd0);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_cnt", 32'(bus.PRESS_CNT), 32'd0);
    rst = 1'b0;
    tick(2);

    // Clean press, code 01.
    press(2'b01, 10);
    chk("clean_pending", 32'(q.size()), 32'd0);
    chk("clean_code", 32'(bus.COIN_CODE), 32'd1);
    chk("clean_cnt", 32'(bus.PRESS_CNT), 32'd1);
    chk("clean_busy", 32'(bus.BUSY), 32'd0);

    // Glitch: three cycles high is one short of acceptance.
    bus.BTNC = 1'b1;
    tick(3);
    chk("glitch_busy_mid", 32'(bus.BUSY), 32'd1);
    bus.BTNC = 1'b0;
    tick(8);
    chk("glitch_busy", 32'(bus.BUSY), 32'd0);
    chk("glitch_cnt", 32'(bus.PRESS_CNT), 32'(exp_cnt));
    chk("glitch_pending", 32'(q.size()), 32'd0);

    // Bouncy press and release: exactly one strobe from the final rise.
    {bus.SW1, bus.SW0} = 2'b10;
    bus.BTNC = 1'b1; tick(1);
    bus.BTNC = 1'b0; tick(1);
    bus.BTNC = 1'b1; tick(1);
    bus.BTNC = 1'b0; tick(1);
    bus.BTNC = 1'b1;
    expect_strobe(2'b10);
    tick(8);
    bus.BTNC = 1'b0; tick(1);
    bus.BTNC = 1'b1; tick(1);
    bus.BTNC = 1'b0; tick(1);
    bus.BTNC = 1'b1; tick(1);
    bus.BTNC = 1'b0;
    tick(12);
    chk("bouncy_pending", 32'(q.size()), 32'd0);
    chk("bouncy_cnt", 32'(bus.PRESS_CNT), 32'(exp_cnt));
    chk("bouncy_busy", 32'(bus.BUSY), 32'd0);

    // Switch change while held does not alter the captured code.
    {bus.SW1, bus.SW0} = 2'b10;
    tick(1);
    bus.BTNC = 1'b1;
    expect_strobe(2'b10);
    tick(8);
    {bus.SW1, bus.SW0} = 2'b00;
    tick(4);
    bus.BTNC = 1'b0;
    tick(10);
    chk("swheld_code", 32'(bus.COIN_CODE), 32'd2);
    chk("swheld_pending", 32'(q.size()), 32'd0);
    press(2'b00, 10);
    chk("swnext_code", 32'(bus.COIN_CODE), 32'd0);

    // Code 11 passes through unchanged.
    press(2'b11, 10);
    chk("code11_code", 32'(bus.COIN_CODE), 32'd3);
    chk("code11_pending", 32'(q.size()), 32'd0);

    // Reset mid-press while BTNC stays held: fresh press after release of RST.
    {bus.SW1, bus.SW0} = 2'b01;
    bus.BTNC = 1'b1;
    tick(4);
    chk("midrst_busy_before", 32'(bus.BUSY), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(bus.COIN_VALID), 32'd0);
    chk("midrst_code", 32'(bus.COIN_CODE), 32'd0);
    chk("midrst_busy", 32'(bus.BUSY), 32'd0);
    chk("midrst_cnt", 32'(bus.PRESS_CNT), 32'd0);
    q.delete();
    exp_cnt = 8'd0;
    tick(2);
    rst = 1'b0;
    expect_strobe(2'b01);
    tick(10);
    bus.BTNC = 1'b0;
    tick(10);
    chk("midrst_pending", 32'(q.size()), 32'd0);
    chk("midrst_cnt_after", 32'(bus.PRESS_CNT), 32'd1);

    // Wrap: 256 presses from a cleared count, the last one with code 11.
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_cnt = 8'd0;
    chk("wrap_start_cnt", 32'(bus.PRESS_CNT), 32'd0);
    for (int i = 1; i <= 256; i++) begin
      press((i == 256) ? 2'b11 : 2'(i % 3), 7);
    end
    chk("wrap_cnt", 32'(bus.PRESS_CNT), 32'd0);
    chk("wrap_code", 32'(bus.COIN_CODE), 32'd3);
    chk("wrap_pending", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
